// File: rtl/rf_dump_reader.sv
// rf_dump_reader
//   Debug-side reader for the 32x32 CPU register file. On a start pulse it
//   walks registers FIRST_REG..LAST_REG through one read port. Each word is
//   captured and streamed out on a valid/ready interface, tagged with its
//   register index. The pipeline is held for the whole dump, so the words
//   form a consistent snapshot.
//
// Ports
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   start      : dump request, sampled only in IDLE
//   rd_addr    : register-file read address
//   rd_data    : register-file read data, valid RD_LAT posedges after rd_addr
//   hold       : pipeline write-inhibit, equal to busy
//   busy       : dump in progress, from the first WAIT through DONE
//   done       : one-cycle pulse after the final handshake
//   out_valid  : stream word valid
//   out_ready  : stream consumer ready
//   out_data   : captured register value
//   out_idx    : register index of out_data
//   out_last   : marks the word for LAST_REG
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, rd_addr parked at FIRST_REG
// WAIT  | rd_addr stable, counting down the register-file read latency
// SEND  | word presented on the stream, waiting for the handshake
// DONE  | one-cycle done pulse, then back to IDLE
module rf_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        hold,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last
);

  generate
    if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG || RD_LAT < 1) begin : g_bad_params
      $error("rf_dump_reader: illegal FIRST_REG/LAST_REG/RD_LAT combination");
    end
  endgenerate

  localparam int               CW       = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0]    LAT_INIT = CW'(RD_LAT);
  localparam logic [CW-1:0]    LAT_ONE  = CW'(1);
  localparam logic [4:0]       FIRST    = 5'(FIRST_REG);
  localparam logic [4:0]       LAST     = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   lat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= FIRST;
      lat_cnt   <= LAT_INIT;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT;
            rd_addr <= FIRST;
            lat_cnt <= LAT_INIT;
          end
        end
        WAIT: begin
          // rd_addr is not touched here so the read in flight stays coherent.
          lat_cnt <= lat_cnt - LAT_ONE;
          if (lat_cnt == LAT_ONE) begin
            out_data  <= rd_data;
            out_idx   <= rd_addr;
            out_last  <= (rd_addr == LAST);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // out_last guards the increment, so rd_addr cannot pass LAST_REG.
              rd_addr <= rd_addr + 5'd1;
              lat_cnt <= LAT_INIT;
              state   <= WAIT;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_addr <= FIRST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // busy decodes directly from the state register, so it carries no extra lag.
  assign busy = (state != IDLE);
  assign hold = busy;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader.
//   Three instances: default range/latency, sub-range 8..10, and RD_LAT=2.
//   Expected words are queued when a dump is started and popped at each handshake.
module tb_rf_dump_reader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic out_ready;
  int   sel;

  always #5 clk = ~clk;

  logic [31:0] rf [32];

  logic        start_v     [3];
  logic [4:0]  rd_addr_v   [3];
  logic [31:0] rd_data_v   [3];
  logic        hold_v      [3];
  logic        busy_v      [3];
  logic        done_v      [3];
  logic        out_valid_v [3];
  logic [31:0] out_data_v  [3];
  logic [4:0]  out_idx_v   [3];
  logic        out_last_v  [3];

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign start_v[g]   = start && (sel == g);
    assign rd_data_v[g] = rf[rd_addr_v[g]];
  end

  rf_dump_reader u_full (
    .clk(clk), .rst(rst), .start(start_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]),
    .hold(hold_v[0]), .busy(busy_v[0]), .done(done_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(out_data_v[0]), .out_idx(out_idx_v[0]), .out_last(out_last_v[0])
  );

  rf_dump_reader #(.FIRST_REG(8), .LAST_REG(10), .RD_LAT(1)) u_sub (
    .clk(clk), .rst(rst), .start(start_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]),
    .hold(hold_v[1]), .busy(busy_v[1]), .done(done_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(out_data_v[1]), .out_idx(out_idx_v[1]), .out_last(out_last_v[1])
  );

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .rd_addr(rd_addr_v[2]), .rd_data(rd_data_v[2]),
    .hold(hold_v[2]), .busy(busy_v[2]), .done(done_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(out_data_v[2]), .out_idx(out_idx_v[2]), .out_last(out_last_v[2])
  );

  logic        m_valid, m_last, m_hold, m_busy, m_done;
  logic [31:0] m_data;
  logic [4:0]  m_idx, m_rd_addr;

  always_comb begin
    m_valid   = out_valid_v[0];
    m_last    = out_last_v[0];
    m_hold    = hold_v[0];
    m_busy    = busy_v[0];
    m_done    = done_v[0];
    m_data    = out_data_v[0];
    m_idx     = out_idx_v[0];
    m_rd_addr = rd_addr_v[0];
    if (sel == 1 || sel == 2) begin
      m_valid   = out_valid_v[sel];
      m_last    = out_last_v[sel];
      m_hold    = hold_v[sel];
      m_busy    = busy_v[sel];
      m_done    = done_v[sel];
      m_data    = out_data_v[sel];
      m_idx     = out_idx_v[sel];
      m_rd_addr = rd_addr_v[sel];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
  endfunction

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  // cyc is the number of the next posedge while sampling at negedge / driving at posedge+2.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int rx_cnt, hold_cnt, hold_bad, done_cnt = 0, done_cyc, idx4_cyc;

  always @(negedge clk) begin
    exp_t e;
    if (m_hold) hold_cnt++;
    if (m_hold !== m_busy) hold_bad++;
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst && m_valid && out_ready) begin
      rx_cnt++;
      if (m_idx == 5'd4) idx4_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(m_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("word_idx", 32'(m_idx), 32'(e.idx));
        chk("word_data", m_data, e.data);
        chk("word_last", 32'(m_last), 32'(e.last));
        if (e.at >= 0) chk("hs_edge", cyc, e.at);
      end
    end
  end

  int cur_e, cur_n, cur_lat, done_before;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_dump(input int first, input int last, input int lat, input bit use_edges);
    exp_t e;
    exp_q.delete();
    cur_e   = cyc;
    cur_n   = last - first + 1;
    cur_lat = lat;
    for (int i = first; i <= last; i++) begin
      e.idx  = 5'(i);
      e.data = exp_data(i);
      e.last = (i == last);
      e.at   = use_edges ? cur_e + (lat + 1) * (i - first + 1) : -1;
      exp_q.push_back(e);
    end
    rx_cnt      = 0;
    hold_cnt    = 0;
    hold_bad    = 0;
    done_before = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int b = 0;
    while (done_cnt == done_before && b < bound) begin
      step();
      b++;
    end
    chk("done_in_time", 32'(b < bound), 32'd1);
    repeat (3) step();
  endtask

  task automatic end_checks(input int extra);
    chk("done_count", done_cnt - done_before, 1);
    chk("done_cycle", done_cyc, cur_e + (cur_lat + 1) * cur_n + extra + 1);
    chk("word_count", rx_cnt, cur_n);
    chk("queue_left", exp_q.size(), 0);
    chk("hold_cycles", hold_cnt, (cur_lat + 1) * cur_n + extra + 1);
    chk("hold_eq_busy", hold_bad, 0);
    chk("busy_after", 32'(m_busy), 0);
    chk("rd_addr_park", 32'(m_rd_addr), (sel == 1) ? 8 : 0);
  endtask

  initial begin
    int b;
    int r_edge;
    for (int i = 0; i < 32; i++) rf[i] = exp_data(i);
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; sel = 0;
    repeat (2) step();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_rd_addr", 32'(m_rd_addr), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", m_data, 0);
    chk("rst_idx", 32'(m_idx), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_hold", 32'(m_hold), 0);
    chk("rst_done", 32'(m_done), 0);
    chk("rst_sub_rd_addr", 32'(rd_addr_v[1]), 8);
    step();

    // full dump, ready always high
    begin_dump(0, 31, 1, 1);
    wait_done(200);
    end_checks(0);

    // start pulses while busy are ignored
    begin_dump(0, 31, 1, 1);
    b = 0;
    while (cyc != cur_e + 5 && b < 50) begin step(); b++; end
    start = 1'b1; step(); start = 1'b0;
    while (cyc != cur_e + 30 && b < 50) begin step(); b++; end
    start = 1'b1; step(); start = 1'b0;
    wait_done(200);
    end_checks(0);

    // back-pressure on idx 3
    begin_dump(0, 31, 1, 0);
    b = 0;
    while (!(m_valid && m_idx == 5'd3) && b < 50) begin step(); b++; end
    chk("bp_saw_idx3", 32'(b < 50), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", m_data, 32'h1000_0003);
      chk("bp_idx", 32'(m_idx), 3);
      step();
    end
    r_edge = cyc;
    out_ready = 1'b1;
    wait_done(200);
    chk("bp_idx4_edge", idx4_cyc, r_edge + 2);
    end_checks(5);

    // reset while idx 12 is valid
    begin_dump(0, 31, 1, 1);
    b = 0;
    while (!(m_valid && m_idx == 5'd12) && b < 100) begin step(); b++; end
    chk("abort_saw_idx12", 32'(b < 100), 1);
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(m_valid), 0);
    chk("abort_busy", 32'(m_busy), 0);
    chk("abort_hold", 32'(m_hold), 0);
    chk("abort_done", 32'(m_done), 0);
    chk("abort_rd_addr", 32'(m_rd_addr), 0);
    chk("abort_data", m_data, 0);
    step();
    repeat (5) step();
    chk("abort_no_done", done_cnt - done_before, 0);
    out_ready = 1'b1;
    begin_dump(0, 31, 1, 1);
    wait_done(200);
    end_checks(0);

    // sub-range 8..10
    sel = 1;
    step();
    begin_dump(8, 10, 1, 1);
    wait_done(50);
    end_checks(0);

    // read latency 2
    sel = 2;
    step();
    begin_dump(0, 31, 2, 1);
    wait_done(300);
    end_checks(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
